// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared FSM encoding and address field widths for the direct-mapped L1 cache
package l1_cache_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, ALLOCATE = 2'd2} state_t;
  localparam int BLOCK_W = 128;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 30;
  localparam int OFFSET_W = 2;
  function automatic int tag_w(input int index_w);
    return ADDR_W - OFFSET_W - index_w;
  endfunction
endpackage

// File: rtl/l1_cache_array.sv
// l1_cache_array: valid/dirty/tag/data storage with word-write, block-fill and combinational line read
module l1_cache_array
  import l1_cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$clog2(NUM_BLOCKS)-1:0]      index,
  input  logic [OFFSET_W-1:0]                offset,
  input  logic                               word_we,
  input  logic [WORD_W-1:0]                  word_data,
  input  logic                               fill_we,
  input  logic [tag_w($clog2(NUM_BLOCKS))-1:0] fill_tag,
  input  logic [BLOCK_W-1:0]                 fill_data,
  input  logic                               clean,
  output logic                               valid,
  output logic                               dirty,
  output logic [tag_w($clog2(NUM_BLOCKS))-1:0] tag,
  output logic [BLOCK_W-1:0]                 data
);
  localparam int TAG_W = tag_w($clog2(NUM_BLOCKS));
  logic [NUM_BLOCKS-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [NUM_BLOCKS];
  logic [BLOCK_W-1:0] data_q [NUM_BLOCKS];
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_we) valid_q[index] <= 1'b1;
      if (fill_we || clean) dirty_q[index] <= 1'b0;
      else if (word_we) dirty_q[index] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[index] <= fill_tag;
      data_q[index] <= fill_data;
    end else if (word_we) begin
      data_q[index][{offset, 5'b0} +: WORD_W] <= word_data;
    end
  end
  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag = tag_q[index];
  assign data = data_q[index];
endmodule

// File: rtl/l1_cache_dm.sv
// l1_cache_dm: direct-mapped write-back write-allocate L1 cache with a 128-bit block memory port
module l1_cache_dm
  import l1_cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam int INDEX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = tag_w(INDEX_W);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  state_t state, state_nxt;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0] tag, line_tag;
  logic [OFF_W-1:0] offset;
  logic [BLOCK_W-1:0] line_data;
  logic line_valid, line_dirty, req, hit;
  assign offset = proc_addr[OFF_W-1:0];
  assign index = proc_addr[INDEX_W+1:2];
  assign tag = proc_addr[29:INDEX_W+2];
  assign req = proc_read | proc_write;
  assign hit = line_valid && line_tag == tag;
  assign proc_rdata = line_data[{offset, 5'b0} +: WORD_W];
  assign mem_wdata = line_data;
  l1_cache_array #(.NUM_BLOCKS(NUM_BLOCKS)) u_array (
    .clk       (clk),
    .rst       (proc_reset),
    .index     (index),
    .offset    (offset),
    .word_we   (state == IDLE && proc_write && hit),
    .word_data (proc_wdata),
    .fill_we   (state == ALLOCATE && mem_ready),
    .fill_tag  (tag),
    .fill_data (mem_rdata),
    .clean     (state == WRITEBACK && mem_ready),
    .valid     (line_valid),
    .dirty     (line_dirty),
    .tag       (line_tag),
    .data      (line_data)
  );
  always_ff @(posedge clk) state <= proc_reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    proc_stall = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_addr = {tag, index};
    case (state)
      IDLE: begin
        proc_stall = req && !hit;
        if (req && !hit) state_nxt = line_dirty ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write = 1'b1;
        mem_addr = {line_tag, index};
        if (mem_ready) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_l1_cache_dm.sv
// tb_l1_cache_dm: table, directed and random checks of l1_cache_dm against an architectural memory model
module tb_l1_cache_dm;
  logic clk = 1'b0;
  logic proc_reset, proc_read, proc_write, proc_stall, mem_read, mem_write, mem_ready;
  logic [29:0] proc_addr;
  logic [31:0] proc_wdata, proc_rdata;
  logic [27:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  int vectors = 0, miscompares = 0;
  logic [31:0] arch [logic [29:0]];
  logic mv [8];
  logic md [8];
  logic [24:0] mt [8];
  typedef struct packed {
    logic stall0, wb, fill, unstable, timeout, stall_end, mem_end;
    logic [15:0] cycles;
    logic [27:0] wb_addr, fill_addr;
    logic [127:0] wb_data;
    logic [31:0] rdata;
  } obs_t;
  typedef struct {
    logic w;
    logic [29:0] a;
    logic [31:0] d;
    logic miss, wb;
    logic [27:0] wb_addr;
    logic [1:0] wsel;
    logic [31:0] wword;
    logic [27:0] fill_addr;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl [7];
  always #5 clk = ~clk;
  l1_cache_dm dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );
  function automatic logic [31:0] pat(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h9E37_79B9;
  endfunction
  function automatic logic [31:0] rd_arch(input logic [29:0] a);
    return arch.exists(a) ? arch[a] : pat(a);
  endfunction
  function automatic logic [127:0] blk(input logic [27:0] b);
    return {rd_arch({b, 2'd3}), rd_arch({b, 2'd2}), rd_arch({b, 2'd1}), rd_arch({b, 2'd0})};
  endfunction
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
    end
  endtask
  task automatic do_op(input logic w, input logic [29:0] a, input logic [31:0] d, input int lat, output obs_t o);
    logic [27:0] ad;
    logic [127:0] wd;
    logic wr;
    int n;
    o = '0;
    n = 0;
    @(negedge clk);
    proc_read = !w;
    proc_write = w;
    proc_addr = a;
    proc_wdata = d;
    #1;
    o.stall0 = proc_stall;
    while (proc_stall && n < 200) begin
      if (mem_read || mem_write) begin
        ad = mem_addr;
        wd = mem_wdata;
        wr = mem_write;
        if (mem_read && mem_write) o.unstable = 1'b1;
        if (wr) begin
          o.wb = 1'b1;
          o.wb_addr = ad;
          o.wb_data = wd;
        end else begin
          o.fill = 1'b1;
          o.fill_addr = ad;
          mem_rdata = blk(ad);
        end
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          #1;
          n++;
          if (mem_write !== wr || mem_read !== !wr || mem_addr !== ad || (wr && mem_wdata !== wd) || proc_stall !== 1'b1)
            o.unstable = 1'b1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n++;
      end else begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    o.timeout = proc_stall;
    o.cycles = 16'(n);
    o.stall_end = proc_stall;
    o.mem_end = mem_read | mem_write;
    o.rdata = proc_rdata;
    @(negedge clk);
    proc_read = 1'b0;
    proc_write = 1'b0;
  endtask
  task automatic model_op(input logic w, input logic [29:0] a, input logic [31:0] d, input int lat, output obs_t o);
    logic [2:0] i;
    logic [24:0] t;
    logic miss, wb;
    logic [27:0] victim;
    logic [127:0] vdata;
    logic [31:0] exp_rd;
    int exp_cyc;
    i = a[4:2];
    t = a[29:5];
    miss = !(mv[i] && mt[i] == t);
    wb = miss && md[i];
    victim = {mt[i], i};
    vdata = blk(victim);
    exp_rd = rd_arch(a);
    exp_cyc = miss ? (wb ? 2 * lat + 3 : lat + 2) : 0;
    do_op(w, a, d, lat, o);
    chk("miss_stall", o.stall0, miss);
    chk("writeback", o.wb, wb);
    if (wb && o.wb) begin
      chk("wb_addr", o.wb_addr, victim);
      chk("wb_data", o.wb_data, vdata);
    end
    chk("fill", o.fill, miss);
    if (miss && o.fill) chk("fill_addr", o.fill_addr, a[29:2]);
    chk("held_stable", o.unstable, 0);
    chk("timeout", o.timeout, 0);
    chk("penalty", o.cycles, exp_cyc);
    chk("stall_end", o.stall_end, 0);
    chk("idle_mem", o.mem_end, 0);
    if (!w) chk("rdata", o.rdata, exp_rd);
    if (miss) begin
      mv[i] = 1'b1;
      mt[i] = t;
      md[i] = 1'b0;
    end
    if (w) begin
      arch[a] = d;
      md[i] = 1'b1;
    end
  endtask
  initial begin
    obs_t o;
    logic [29:0] a;
    proc_reset = 1'b1;
    proc_read = 1'b0;
    proc_write = 1'b0;
    proc_addr = '0;
    proc_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", proc_stall, 0);
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_write", mem_write, 0);
    proc_reset = 1'b0;
    arch[30'h10] = 32'hAAAAAAAA;
    arch[30'h11] = 32'hBBBBBBBB;
    arch[30'h12] = 32'hCCCCCCCC;
    arch[30'h13] = 32'hDDDDDDDD;
    tbl[0] = '{1'b0, 30'h10, 32'h0, 1'b1, 1'b0, 28'h0, 2'd0, 32'h0, 28'h4, 32'hAAAAAAAA};
    tbl[1] = '{1'b0, 30'h13, 32'h0, 1'b0, 1'b0, 28'h0, 2'd0, 32'h0, 28'h0, 32'hDDDDDDDD};
    tbl[2] = '{1'b1, 30'h11, 32'h12345678, 1'b0, 1'b0, 28'h0, 2'd0, 32'h0, 28'h0, 32'h0};
    tbl[3] = '{1'b0, 30'h31, 32'h0, 1'b1, 1'b1, 28'h4, 2'd1, 32'h12345678, 28'hC, pat(30'h31)};
    tbl[4] = '{1'b1, 30'h08, 32'hCAFEF00D, 1'b1, 1'b0, 28'h0, 2'd0, 32'h0, 28'h2, 32'h0};
    tbl[5] = '{1'b0, 30'h08, 32'h0, 1'b0, 1'b0, 28'h0, 2'd0, 32'h0, 28'h0, 32'hCAFEF00D};
    tbl[6] = '{1'b0, 30'h28, 32'h0, 1'b1, 1'b1, 28'h2, 2'd0, 32'hCAFEF00D, 28'hA, pat(30'h28)};
    for (int v = 0; v < 7; v++) begin
      model_op(tbl[v].w, tbl[v].a, tbl[v].d, 1, o);
      chk($sformatf("tbl%0d_miss", v), o.stall0, tbl[v].miss);
      chk($sformatf("tbl%0d_wb", v), o.wb, tbl[v].wb);
      if (tbl[v].wb) begin
        chk($sformatf("tbl%0d_wb_addr", v), o.wb_addr, tbl[v].wb_addr);
        chk($sformatf("tbl%0d_wb_word", v), o.wb_data[{tbl[v].wsel, 5'b0} +: 32], tbl[v].wword);
      end
      if (tbl[v].miss) chk($sformatf("tbl%0d_fill_addr", v), o.fill_addr, tbl[v].fill_addr);
      if (!tbl[v].w) chk($sformatf("tbl%0d_rdata", v), o.rdata, tbl[v].rdata);
    end
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h10;
    #1;
    chk("rst_seq_stall", proc_stall, 1);
    @(negedge clk);
    #1;
    chk("rst_seq_alloc", mem_read, 1);
    proc_reset = 1'b1;
    proc_read = 1'b0;
    @(negedge clk);
    #1;
    proc_reset = 1'b0;
    chk("rst_seq_mem_read", mem_read, 0);
    chk("rst_seq_mem_write", mem_write, 0);
    chk("rst_seq_stall_low", proc_stall, 0);
    model_reset();
    model_op(1'b0, 30'h10, 32'h0, 2, o);
    chk("rst_refetch_miss", o.stall0, 1);
    model_op(1'b1, 30'h10, 32'h600DF00D, 1, o);
    model_op(1'b0, 30'h30, 32'h0, 10, o);
    chk("delay_wb_seen", o.wb, 1);
    chk("delay_wb_addr", o.wb_addr, 28'h4);
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    model_op(1'b0, 30'h30, 32'h0, 1, o);
    chk("idle_ready_hit", o.stall0, 0);
    for (int k = 0; k < 400; k++) begin
      a = 30'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a[29:7] = 23'($urandom);
      model_op(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 4)), o);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
